// File: rtl/drv_meas.sv
// drv_meas: measures the two-channel gate-drive waveform fed back from fixed_driver.
// For each ch0 period it reports the period, the high time of each channel, the
// ch0->ch1 phase and a missing-ch1 flag, all in clk ticks. It raises a stall flag
// when ch0 stops toggling.
// Optional build macro DRV_MEAS_GLITCH_EN inserts a FILT_LEN-cycle stability
// filter after the synchronizer.
module drv_meas #(
    parameter int CNT_BITS      = 24,
    parameter int TIMEOUT_TICKS = 200000,
    parameter int FILT_LEN      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          drv_in,
    output logic [CNT_BITS-1:0] meas_period,
    output logic [CNT_BITS-1:0] meas_high0,
    output logic [CNT_BITS-1:0] meas_high1,
    output logic [CNT_BITS-1:0] meas_phase,
    output logic                ch1_miss,
    output logic                meas_val,
    output logic                stalled,
    output logic [15:0]         meas_cnt
);

    localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] TIMEOUT_C = CNT_BITS'(TIMEOUT_TICKS);

    typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic [1:0]          sync_p0;
    logic [1:0]          sync_p1;
    logic [1:0]          lvl;
    logic [1:0]          lvl_prev;
    logic [1:0]          rise;

    logic [CNT_BITS-1:0] tick;
    logic [CNT_BITS-1:0] hi0;
    logic [CNT_BITS-1:0] hi1;
    logic [CNT_BITS-1:0] phase;
    logic                seen;

    state_t              state;

    // Two-flop synchronizer for the asynchronous drive pins.
    always_ff @(posedge clk) begin
        sync_p0 <= drv_in;
        sync_p1 <= sync_p0;
    end

`ifdef DRV_MEAS_GLITCH_EN
    localparam int FCW = $clog2(FILT_LEN + 1);

    logic [1:0]     filt_p2;
    logic [FCW-1:0] fcnt_p2 [2];

    // Stability filter: a channel level changes only after FILT_LEN consecutive
    // cycles at the new value, so short glitches never reach the edge detector.
    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (sync_p1[c] == filt_p2[c]) begin
                fcnt_p2[c] <= '0;
            end else if (fcnt_p2[c] == FCW'(FILT_LEN - 1)) begin
                filt_p2[c] <= sync_p1[c];
                fcnt_p2[c] <= '0;
            end else begin
                fcnt_p2[c] <= fcnt_p2[c] + FCW'(1);
            end
        end
    end

    assign lvl = filt_p2;
`else
    assign lvl = sync_p1;
`endif

    // Previous level for edge detection; not reset so that a reset while a pin
    // is high does not fabricate a rising edge.
    always_ff @(posedge clk) begin
        lvl_prev <= lvl;
    end

    assign rise = lvl & ~lvl_prev;

    // Window counters: a ch0 rise closes the current window and opens the next,
    // with the opening cycle counted as tick 0 (so tick holds the next cycle's index).
    always_ff @(posedge clk) begin
        if (rise[0]) begin
            tick  <= CNT_ONE;
            hi0   <= CNT_ONE;
            hi1   <= lvl[1] ? CNT_ONE : '0;
            phase <= '0;
            seen  <= rise[1];
        end else begin
            tick <= sat_inc(tick);
            if (lvl[0]) begin
                hi0 <= sat_inc(hi0);
            end
            if (lvl[1]) begin
                hi1 <= sat_inc(hi1);
            end
            if (rise[1] && !seen) begin
                phase <= tick;
                seen  <= 1'b1;
            end
        end
    end

    // Measurement FSM: publishes the closed window on each ch0 rise and falls into
    // STALL when ch0 goes quiet; a rise on the timeout cycle takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            meas_period <= '0;
            meas_high0  <= '0;
            meas_high1  <= '0;
            meas_phase  <= '0;
            ch1_miss    <= 1'b0;
            meas_val    <= 1'b0;
            stalled     <= 1'b0;
            meas_cnt    <= '0;
        end else begin
            meas_val <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise[0]) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (rise[0]) begin
                        meas_period <= tick;
                        meas_high0  <= hi0;
                        meas_high1  <= hi1;
                        meas_phase  <= seen ? phase : '0;
                        ch1_miss    <= !seen;
                        meas_val    <= 1'b1;
                        meas_cnt    <= meas_cnt + 16'd1;
                    end else if (tick >= TIMEOUT_C) begin
                        state       <= STALL;
                        stalled     <= 1'b1;
                        meas_period <= '0;
                        meas_high0  <= '0;
                        meas_high1  <= '0;
                        meas_phase  <= '0;
                        ch1_miss    <= 1'b1;
                    end
                end
                STALL: begin
                    if (rise[0]) begin
                        stalled <= 1'b0;
                        state   <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drv_meas.sv
// tb_drv_meas: vector table of steady waveforms plus hand-built sequences for
// reset mid-window, stall/restart and a ch0 glitch; a scoreboard queue carries
// the expected measurement for every ch0 rise that should close a window.
module tb_drv_meas;

    localparam int CNT_BITS = 24;
    localparam int TIMEOUT  = 3000;
    localparam int FILT     = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          drv_in;
    logic [CNT_BITS-1:0] meas_period;
    logic [CNT_BITS-1:0] meas_high0;
    logic [CNT_BITS-1:0] meas_high1;
    logic [CNT_BITS-1:0] meas_phase;
    logic                ch1_miss;
    logic                meas_val;
    logic                stalled;
    logic [15:0]         meas_cnt;

    drv_meas #(
        .CNT_BITS(CNT_BITS),
        .TIMEOUT_TICKS(TIMEOUT),
        .FILT_LEN(FILT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .drv_in(drv_in),
        .meas_period(meas_period),
        .meas_high0(meas_high0),
        .meas_high1(meas_high1),
        .meas_phase(meas_phase),
        .ch1_miss(ch1_miss),
        .meas_val(meas_val),
        .stalled(stalled),
        .meas_cnt(meas_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int period;
        int high0;
        int high1;
        int phase;
        int miss;
    } exp_t;

    typedef struct {
        int   period;
        int   high0;
        int   d1;
        int   high1;
        int   nper;
        exp_t e;
    } vec_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [15:0] exp_cnt = '0;
    int          cyc = 0;
    int          last_val_cyc = 0;
    int          stall_cyc = -1;
    logic        prev_rst = 1'b0;
    logic        prev_stalled = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Monitor: checks reset values, pops the scoreboard on each strobe, tracks stall timing.
    always @(negedge clk) begin
        cyc++;
        if (prev_rst) begin
            chk("rst_meas_zero", {meas_period, meas_high0, meas_high1, meas_phase}, 0);
            chk("rst_flags_zero", {ch1_miss, meas_val, stalled}, 0);
            chk("rst_cnt_zero", meas_cnt, 0);
            exp_cnt = '0;
        end else if (meas_val) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("period", meas_period, e.period);
                chk("high0", meas_high0, e.high0);
                chk("high1", meas_high1, e.high1);
                chk("phase", meas_phase, e.phase);
                chk("ch1_miss", ch1_miss, e.miss);
                exp_cnt = exp_cnt + 16'd1;
                chk("meas_cnt", meas_cnt, exp_cnt);
                chk("no_stall_on_val", stalled, 0);
            end
            last_val_cyc = cyc;
        end
        if (stalled && !prev_stalled) stall_cyc = cyc;
        prev_stalled = stalled;
        prev_rst = rst;
    end

    // Drives nper periods of the vector waveform; optional reset pulse and ch0 glitch.
    task automatic drive_wave(input vec_t v, input int rst_per, input int rst_off,
                              input int g_per, input int g_off, input int g_len,
                              input exp_t ga, input exp_t gb);
        logic b0, b1;
        for (int k = 0; k < v.nper; k++) begin
            for (int t = 0; t < v.period; t++) begin
                @(posedge clk);
                #1;
                b0 = (t < v.high0) || (k == g_per && t >= g_off && t < g_off + g_len);
                b1 = (t >= v.d1) && (t < v.d1 + v.high1);
                drv_in = {b1, b0};
                rst = (k == rst_per && t == rst_off);
                if (t == 0 && k >= 1 && k != rst_per + 1) begin
`ifndef DRV_MEAS_GLITCH_EN
                    if (k == g_per + 1) sb.push_back(gb);
                    else sb.push_back(v.e);
`else
                    sb.push_back(v.e);
`endif
                end
`ifndef DRV_MEAS_GLITCH_EN
                if (k == g_per && t == g_off) sb.push_back(ga);
`endif
            end
        end
        @(posedge clk);
        #1;
        drv_in = 2'b00;
        rst = 1'b0;
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (20) @(posedge clk);
        chk(name, sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vec_t v0;
        exp_t none;
        exp_t ga;
        exp_t gb;
        int   w;

        //           period high0 d1   high1 nper  {period high0 high1 phase miss}
        vecs[0] = '{1000, 400, 250, 400, 4, '{1000, 400, 400, 250, 0}};
        vecs[1] = '{1000, 400,   0,   0, 4, '{1000, 400,   0,   0, 1}};
        vecs[2] = '{1000, 400,   0, 400, 4, '{1000, 400, 400,   0, 0}};
        vecs[3] = '{ 500, 100, 300, 150, 4, '{ 500, 100, 150, 300, 0}};
        vecs[4] = '{ 300, 290,   5, 290, 4, '{ 300, 290, 290,   5, 0}};
        vecs[5] = '{3000, 100,   0,   0, 3, '{3000, 100,   0,   0, 1}};
        none = '{0, 0, 0, 0, 0};
        v0 = vecs[0];

        rst = 1'b1;
        drv_in = 2'b00;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);

        // Steady waveforms, reset between each so every vector starts from IDLE.
        for (int i = 0; i < 6; i++) begin
            drive_wave(vecs[i], -1, 0, -1, 0, 0, none, none);
            drain("sb_drained_vec");
            pulse_rst();
            repeat (5) @(posedge clk);
        end

        // Reset mid-window: rise after reset only reopens, the next one reports.
        drive_wave(v0, 2, 500, -1, 0, 0, none, none);
        drain("sb_drained_rst");
        pulse_rst();

        // 2-cycle ch0 glitch at offset 700 of period 2.
        ga = '{700, 400, 400, 250, 0};
        gb = '{300, 2, 0, 0, 1};
        drive_wave(v0, -1, 0, 2, 700, 2, ga, gb);
        drain("sb_drained_glitch");
        pulse_rst();

        // Stall: three measurements, then ch0 stops.
        drive_wave(v0, -1, 0, -1, 0, 0, none, none);
        w = 0;
        while (!stalled && w < TIMEOUT + 2000) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        chk("stall_seen", stalled, 1);
        chk("stall_latency", stall_cyc - last_val_cyc, TIMEOUT);
        chk("stall_meas_zero", {meas_period, meas_high0, meas_high1, meas_phase}, 0);
        chk("stall_ch1_miss", ch1_miss, 1);
        chk("stall_cnt_hold", meas_cnt, 3);
        chk("sb_drained_stall", sb.size(), 0);

        // Restart: first rise only clears stalled, following rises report.
        v0.nper = 3;
        drive_wave(v0, -1, 0, -1, 0, 0, none, none);
        chk("restart_unstalled", stalled, 0);
        drain("sb_drained_restart");
        chk("restart_cnt", meas_cnt, 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
